// File: rtl/lfsr_gen_if.sv
// Control and observation bundle for lfsr_gen.
//   master: drives ena/seed/load/load_value/step and observes the outputs.
//   slave : the generator itself.
// Signals:
//   ena, seed        serial seed mode and the bit shifted in
//   load, load_value parallel seed strobe and value
//   step             advance the register by one shift
//   state            register contents
//   out              serial output, state[WIDTH-1]
//   lockup           state is all zeros
//   wrap             one-cycle pulse when the sequence returns to its reference value
//   period           step count of the last completed cycle
interface lfsr_gen_if #(
    parameter int unsigned WIDTH = 8
);
    logic             ena;
    logic             seed;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             step;
    logic [WIDTH-1:0] state;
    logic             out;
    logic             lockup;
    logic             wrap;
    logic [WIDTH-1:0] period;

    modport master (
        output ena, seed, load, load_value, step,
        input  state, out, lockup, wrap, period
    );

    modport slave (
        input  ena, seed, load, load_value, step,
        output state, out, lockup, wrap, period
    );
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with parallel and serial seeding, all-zero
// lockup detection with optional auto-recovery, and a period counter.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset, synchronous release
//   bus  lfsr_gen_if slave modport (controls in, state/out/lockup/wrap/period out)
// Parameters:
//   WIDTH        register length, 3..32
//   TAPS         feedback mask, bit i set means state[i] feeds the XOR
//   RESET_VAL    nonzero value loaded on reset and on auto-recovery
//   AUTO_RECOVER 1: stepping from zero reloads RESET_VAL; 0: register sticks at zero
module lfsr_gen #(
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] RESET_VAL    = WIDTH'(8'h01),
    parameter bit               AUTO_RECOVER = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    lfsr_gen_if.slave   bus
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] state_q,  state_d;
    logic [WIDTH-1:0] ref_q,    ref_d;
    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             wrap_q,   wrap_d;

    logic             fb;
    logic [WIDTH-1:0] shift_nx;
    logic [WIDTH-1:0] seed_nx;
    logic [WIDTH-1:0] cnt_inc;

    // Feedback and candidate next values
    assign fb       = ^(state_q & TAPS);
    assign shift_nx = {state_q[WIDTH-2:0], fb};
    assign seed_nx  = {state_q[WIDTH-2:0], bus.seed};
    // Step counter saturates rather than wrapping back to zero
    assign cnt_inc  = (cnt_q == ALL_ONES) ? cnt_q : cnt_q + WIDTH'(1);

    // Next-state: load > ena > step > hold
    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        wrap_d   = 1'b0;
        if (bus.load) begin
            state_d = bus.load_value;
            ref_d   = bus.load_value;
            cnt_d   = '0;
        end else if (bus.ena) begin
            state_d = seed_nx;
            ref_d   = seed_nx;
            cnt_d   = '0;
        end else if (bus.step) begin
            if (state_q == '0) begin
                // Lockup: either restart from RESET_VAL or stay stuck
                if (AUTO_RECOVER) begin
                    state_d = RESET_VAL;
                    ref_d   = RESET_VAL;
                    cnt_d   = '0;
                end
            end else begin
                state_d = shift_nx;
                cnt_d   = cnt_inc;
                if (shift_nx == ref_q) begin
                    wrap_d   = 1'b1;
                    period_d = cnt_inc;
                    cnt_d    = '0;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RESET_VAL;
            ref_q    <= RESET_VAL;
            cnt_q    <= '0;
            period_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.state  = state_q;
    assign bus.out    = state_q[WIDTH-1];
    assign bus.lockup = (state_q == '0);
    assign bus.wrap   = wrap_q;
    assign bus.period = period_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: three instances (default, no auto-recovery,
// 4-bit) checked against a behavioural model plus directed test-plan checks.
module tb_lfsr_gen;

    logic clk;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    lfsr_gen_if #(.WIDTH(8)) if0 ();
    lfsr_gen_if #(.WIDTH(8)) if1 ();
    lfsr_gen_if #(.WIDTH(4)) if2 ();

    lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .RESET_VAL(8'h01), .AUTO_RECOVER(1'b1))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .RESET_VAL(8'h01), .AUTO_RECOVER(1'b0))
        dut1 (.clk(clk), .rst(rst), .bus(if1));
    lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .RESET_VAL(4'h1), .AUTO_RECOVER(1'b1))
        dut2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model configuration per instance
    int unsigned     cw[3]    = '{8, 8, 4};
    longint unsigned ctaps[3] = '{64'hB8, 64'hB8, 64'hC};
    longint unsigned crv[3]   = '{1, 1, 1};
    bit              car[3]   = '{1'b1, 1'b0, 1'b1};

    typedef struct {
        longint unsigned st;
        longint unsigned rf;
        longint unsigned cnt;
        longint unsigned period;
        bit              wrap;
    } mdl_t;

    mdl_t m[3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint unsigned mask_of(int k);
        return (64'd1 << cw[k]) - 64'd1;
    endfunction

    function automatic void mdl_reset(int k);
        m[k].st     = crv[k];
        m[k].rf     = crv[k];
        m[k].cnt    = 0;
        m[k].period = 0;
        m[k].wrap   = 1'b0;
    endfunction

    // One clock of the generator, written from the behavioural rules
    function automatic mdl_t mdl_next(int k, mdl_t c, bit ld, longint unsigned lv,
                                      bit en, bit sd, bit stp);
        mdl_t            n;
        longint unsigned msk;
        longint unsigned nx;
        longint unsigned inc;
        msk    = mask_of(k);
        n      = c;
        n.wrap = 1'b0;
        if (ld) begin
            n.st  = lv & msk;
            n.rf  = n.st;
            n.cnt = 0;
        end else if (en) begin
            n.st  = ((c.st * 2) + longint'(sd)) & msk;
            n.rf  = n.st;
            n.cnt = 0;
        end else if (stp) begin
            if (c.st == 0) begin
                if (car[k]) begin
                    n.st  = crv[k];
                    n.rf  = crv[k];
                    n.cnt = 0;
                end
            end else begin
                nx    = ((c.st * 2) + longint'($countones(c.st & ctaps[k]) % 2)) & msk;
                inc   = (c.cnt + 1 > msk) ? msk : c.cnt + 1;
                n.st  = nx;
                n.cnt = inc;
                if (nx == c.rf) begin
                    n.wrap   = 1'b1;
                    n.period = inc;
                    n.cnt    = 0;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [31:0] d_state(int k);
        case (k)
            0:       return 32'(if0.state);
            1:       return 32'(if1.state);
            default: return 32'(if2.state);
        endcase
    endfunction

    function automatic logic [31:0] d_period(int k);
        case (k)
            0:       return 32'(if0.period);
            1:       return 32'(if1.period);
            default: return 32'(if2.period);
        endcase
    endfunction

    function automatic logic [2:0] d_flags(int k);
        case (k)
            0:       return {if0.out, if0.lockup, if0.wrap};
            1:       return {if1.out, if1.lockup, if1.wrap};
            default: return {if2.out, if2.lockup, if2.wrap};
        endcase
    endfunction

    task automatic compare_model(int k);
        logic [2:0] f;
        f = d_flags(k);
        chk($sformatf("u%0d_state", k),  d_state(k), 32'(m[k].st));
        chk($sformatf("u%0d_out", k),    32'(f[2]), 32'((m[k].st >> (cw[k] - 1)) & 1));
        chk($sformatf("u%0d_lockup", k), 32'(f[1]), 32'(m[k].st == 0));
        chk($sformatf("u%0d_wrap", k),   32'(f[0]), 32'(m[k].wrap));
        chk($sformatf("u%0d_period", k), d_period(k), 32'(m[k].period));
    endtask

    task automatic drive(int k, bit ld, logic [31:0] lv, bit en, bit sd, bit stp);
        if0.load = 1'b0; if0.load_value = '0; if0.ena = 1'b0; if0.seed = 1'b0; if0.step = 1'b0;
        if1.load = 1'b0; if1.load_value = '0; if1.ena = 1'b0; if1.seed = 1'b0; if1.step = 1'b0;
        if2.load = 1'b0; if2.load_value = '0; if2.ena = 1'b0; if2.seed = 1'b0; if2.step = 1'b0;
        case (k)
            0: begin if0.load = ld; if0.load_value = lv[7:0]; if0.ena = en; if0.seed = sd; if0.step = stp; end
            1: begin if1.load = ld; if1.load_value = lv[7:0]; if1.ena = en; if1.seed = sd; if1.step = stp; end
            2: begin if2.load = ld; if2.load_value = lv[3:0]; if2.ena = en; if2.seed = sd; if2.step = stp; end
            default: ;
        endcase
    endtask

    // Apply one operation to instance k, advance all models, compare k
    task automatic do_op(int k, bit ld, logic [31:0] lv, bit en, bit sd, bit stp);
        drive(k, ld, lv, en, sd, stp);
        @(posedge clk);
        for (int j = 0; j < 3; j++) begin
            if (j == k) m[j] = mdl_next(j, m[j], ld, 64'(lv), en, sd, stp);
            else        m[j] = mdl_next(j, m[j], 1'b0, 0, 1'b0, 1'b0, 1'b0);
        end
        #1;
        compare_model(k);
    endtask

    task automatic apply_reset();
        drive(-1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) mdl_reset(j);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] seed_bits;
        int         wraps;
        logic [7:0] exp_walk[5];
        bit         ld, en, sd, stp;
        logic [31:0] lv;

        seed_bits   = 8'hA5;
        exp_walk[0] = 8'h02; exp_walk[1] = 8'h04; exp_walk[2] = 8'h08;
        exp_walk[3] = 8'h11; exp_walk[4] = 8'h23;

        rst = 1'b0;
        drive(-1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) mdl_reset(j);
        #12;
        // Reset values
        chk("rst_state",  d_state(0), 32'h01);
        chk("rst_out",    32'(if0.out), 32'd0);
        chk("rst_lockup", 32'(if0.lockup), 32'd0);
        chk("rst_wrap",   32'(if0.wrap), 32'd0);
        chk("rst_period", d_period(0), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Five steps from 0x01
        for (int i = 0; i < 5; i++) begin
            do_op(0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
            chk($sformatf("walk%0d", i), d_state(0), 32'(exp_walk[i]));
        end

        // Serial seed 0xA5 from zero, then a full 255-step cycle
        do_op(0, 1'b1, 32'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) do_op(0, 1'b0, 0, 1'b1, seed_bits[i], 1'b0);
        chk("seed_a5", d_state(0), 32'hA5);
        wraps = 0;
        for (int i = 0; i < 255; i++) begin
            do_op(0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
            wraps += int'(if0.wrap);
        end
        chk("wrap_count", 32'(wraps), 32'd1);
        chk("wrap_last",  32'(if0.wrap), 32'd1);
        chk("period_ff",  d_period(0), 32'hFF);
        chk("state_back", d_state(0), 32'hA5);

        // Lockup with auto-recovery
        do_op(0, 1'b1, 32'h00, 1'b0, 1'b0, 1'b0);
        chk("u0_lock_pre", 32'(if0.lockup), 32'd1);
        do_op(0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("u0_recover", d_state(0), 32'h01);

        // Lockup without auto-recovery
        do_op(1, 1'b1, 32'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            do_op(1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
            chk("u1_stuck",  d_state(1), 32'h00);
            chk("u1_lock",   32'(if1.lockup), 32'd1);
            chk("u1_nowrap", 32'(if1.wrap), 32'd0);
        end

        // Load wins over ena and step
        do_op(0, 1'b1, 32'h5A, 1'b1, 1'b1, 1'b1);
        chk("load_prio", d_state(0), 32'h5A);

        // 4-bit instance: full cycle of 15, then asynchronous reset
        apply_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 15; i++) do_op(2, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("w4_wrap",   32'(if2.wrap), 32'd1);
        chk("w4_period", d_period(2), 32'd15);
        #2;
        apply_reset();
        chk("w4_async_wrap",   32'(if2.wrap), 32'd0);
        chk("w4_async_period", d_period(2), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) do_op(2, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        #2;
        apply_reset();
        chk("w4_async_state", d_state(2), 32'h1);
        @(negedge clk);
        rst = 1'b1;

        // Randomized operations on every instance
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 300; i++) begin
                ld  = ($urandom_range(0, 19) == 0);
                en  = ($urandom_range(0, 9) == 0);
                sd  = 1'($urandom_range(0, 1));
                stp = ($urandom_range(0, 9) < 8);
                lv  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
                do_op(k, ld, lv, en, sd, stp);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
